// File: rtl/memory_control.sv
// memory_control: arbitrates instruction and data requests onto a single RAM port.
// Optional watchdog abort on RAM timeout is enabled by defining MEMCTL_WATCHDOG_EN.
module memory_control #(
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic [31:0] iload,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramrdy,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, DACC, IACC, DRSP, IRSP} state_t;

    state_t      r_state;
    logic        w_abort;
    logic        w_done;
    logic [31:0] w_rdata;

`ifdef MEMCTL_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          w_access;

    assign w_access = (r_state == DACC) || (r_state == IACC);
    assign w_abort  = w_access && !ramrdy && (r_cnt == CW'(TIMEOUT - 1));
    assign err      = r_err;

    // Watchdog: count stalled access cycles, latch a sticky error on abort
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == IDLE)
                r_cnt <= '0;
            else if (w_access && !ramrdy)
                r_cnt <= r_cnt + 1'b1;
            if (w_abort)
                r_err <= 1'b1;
        end
    end
`else
    // TIMEOUT only shapes the watchdog; kept referenced so the build stays quiet
    localparam int unused_timeout = TIMEOUT;

    assign w_abort = 1'b0;
    assign err     = 1'b0;
`endif

    assign w_done  = ramrdy || w_abort;
    assign w_rdata = ramrdy ? ramload : 32'hBAD1BAD1;

    // Request arbitration, RAM strobes and response pulses, all registered
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state  <= IDLE;
            iwait    <= 1'b1;
            dwait    <= 1'b1;
            iload    <= '0;
            dload    <= '0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (dREN || dWEN) begin
                        r_state  <= DACC;
                        ramREN   <= !dWEN;
                        ramWEN   <= dWEN;
                        ramaddr  <= daddr;
                        ramstore <= dstore;
                    end else if (iREN) begin
                        r_state  <= IACC;
                        ramREN   <= 1'b1;
                        ramWEN   <= 1'b0;
                        ramaddr  <= iaddr;
                    end
                end
                DACC: begin
                    if (w_done) begin
                        r_state <= DRSP;
                        ramREN  <= 1'b0;
                        ramWEN  <= 1'b0;
                        dwait   <= 1'b0;
                        if (!ramWEN)
                            dload <= w_rdata;
                    end
                end
                IACC: begin
                    if (w_done) begin
                        r_state <= IRSP;
                        ramREN  <= 1'b0;
                        ramWEN  <= 1'b0;
                        iwait   <= 1'b0;
                        iload   <= w_rdata;
                    end
                end
                DRSP: begin
                    r_state <= IDLE;
                    dwait   <= 1'b1;
                end
                IRSP: begin
                    r_state <= IDLE;
                    iwait   <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_control.sv
// tb_memory_control: directed-vector bench for memory_control (TIMEOUT=8).
module tb_memory_control;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        iwait;
    logic [31:0] iload;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = '0;
    logic        ramrdy;
    logic        err;
    logic        auto_rdy = 1'b0;
    logic        man_rdy = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;

    assign ramrdy = auto_rdy ? (ramREN | ramWEN) : man_rdy;

    always #5 CLK = ~CLK;

    memory_control #(.TIMEOUT(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .iload(iload), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramrdy(ramrdy), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    initial begin
        // reset state
        tick(); tick();
        check("rst_iwait", 32'(iwait), 1);
        check("rst_dwait", 32'(dwait), 1);
        check("rst_iload", iload, 0);
        check("rst_dload", dload, 0);
        check("rst_strobes", {30'b0, ramREN, ramWEN}, 0);
        check("rst_ramaddr", ramaddr, 0);
        check("rst_ramstore", ramstore, 0);
        check("rst_err", 32'(err), 0);
        nRST = 1'b1;
        tick();

        // instruction fetch, minimum latency
        auto_rdy = 1'b1;
        ramload = 32'h8C220004;
        iREN = 1'b1; iaddr = 32'h40;
        tick();
        check("if_ramren", 32'(ramREN), 1);
        check("if_ramaddr", ramaddr, 32'h40);
        check("if_iwait_acc", 32'(iwait), 1);
        iREN = 1'b0;
        tick();
        check("if_iwait_rsp", 32'(iwait), 0);
        check("if_iload", iload, 32'h8C220004);
        check("if_ramren_rsp", 32'(ramREN), 0);
        tick();
        check("if_iwait_end", 32'(iwait), 1);

        // simultaneous requests: data first
        iREN = 1'b1; iaddr = 32'h44;
        dREN = 1'b1; daddr = 32'h100;
        ramload = 32'h11112222;
        tick();
        check("arb_ramaddr_d", ramaddr, 32'h100);
        check("arb_ramren_d", 32'(ramREN), 1);
        dREN = 1'b0;
        tick();
        check("arb_dwait", 32'(dwait), 0);
        check("arb_iwait_d", 32'(iwait), 1);
        check("arb_dload", dload, 32'h11112222);
        ramload = 32'h33334444;
        tick();
        check("arb_dwait_end", 32'(dwait), 1);
        tick();
        check("arb_ramaddr_i", ramaddr, 32'h44);
        iREN = 1'b0;
        tick();
        check("arb_iwait", 32'(iwait), 0);
        check("arb_iload", iload, 32'h33334444);

        // write wins over read, dload untouched
        tick();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF;
        ramload = 32'h55556666;
        tick();
        check("wr_ramwen", 32'(ramWEN), 1);
        check("wr_ramren", 32'(ramREN), 0);
        check("wr_ramstore", ramstore, 32'hDEADBEEF);
        check("wr_ramaddr", ramaddr, 32'h200);
        dREN = 1'b0; dWEN = 1'b0;
        tick();
        check("wr_dwait", 32'(dwait), 0);
        check("wr_dload", dload, 32'h11112222);
        check("wr_iload", iload, 32'h33334444);
        tick();

        // ramrdy delayed 5 access cycles
        auto_rdy = 1'b0;
        dREN = 1'b1; daddr = 32'h300; ramload = 32'h77778888;
        tick();
        dREN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("dly_dwait%0d", i), 32'(dwait), 1);
            tick();
        end
        check("dly_ramren", 32'(ramREN), 1);
        man_rdy = 1'b1;
        tick();
        man_rdy = 1'b0;
        check("dly_dwait_low", 32'(dwait), 0);
        check("dly_dload", dload, 32'h77778888);
        tick();
        check("dly_dwait_one", 32'(dwait), 1);

        // ramrdy in IDLE ignored
        man_rdy = 1'b1;
        tick();
        check("idle_rdy_dwait", 32'(dwait), 1);
        check("idle_rdy_iwait", 32'(iwait), 1);
        man_rdy = 1'b0;
        tick();

        // RAM never answers a read
        dREN = 1'b1; daddr = 32'h400;
        tick();
        dREN = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("wd_dwait%0d", i), 32'(dwait), 1);
            tick();
        end
        check("wd_err_before", 32'(err), 0);
`ifdef MEMCTL_WATCHDOG_EN
        tick();
        check("wd_dwait_low", 32'(dwait), 0);
        check("wd_dload", dload, 32'hBAD1BAD1);
        check("wd_err", 32'(err), 1);
        tick(); tick();
        check("wd_dwait_end", 32'(dwait), 1);
        check("wd_err_sticky", 32'(err), 1);
`else
        for (int i = 0; i < 4; i++) tick();
        check("nowd_dwait", 32'(dwait), 1);
        check("nowd_ramren", 32'(ramREN), 1);
        check("nowd_err", 32'(err), 0);
        man_rdy = 1'b1;
        ramload = 32'h9999AAAA;
        tick();
        man_rdy = 1'b0;
        check("nowd_dwait_low", 32'(dwait), 0);
        check("nowd_dload", dload, 32'h9999AAAA);
        tick();
`endif
        tick();

        // reset mid-access
        dREN = 1'b1; daddr = 32'h500;
        tick();
        check("rm_ramren", 32'(ramREN), 1);
        dREN = 1'b0;
        nRST = 1'b0;
        tick();
        check("rm_ramren_rst", 32'(ramREN), 0);
        check("rm_ramaddr", ramaddr, 0);
        check("rm_dwait", 32'(dwait), 1);
        check("rm_dload", dload, 0);
        check("rm_iload", iload, 0);
        check("rm_err", 32'(err), 0);
        nRST = 1'b1;
        man_rdy = 1'b1;
        tick();
        check("rm_dwait_after", 32'(dwait), 1);
        check("rm_ramren_after", 32'(ramREN), 0);
        man_rdy = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_control.md
MEMORY_CONTROL -- requirements
Module: memory_control

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of access-state cycles to wait for ramrdy before abort.
REQ-002 SHALL have port CLK  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port nRST  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports iREN input 1 instruction read request; iaddr input 32 instruction word address.
REQ-005 SHALL have ports dREN input 1 data read request; dWEN input 1 data write request; daddr input 32 data address; dstore input 32 write data.
REQ-006 SHALL have ports iwait output 1 instruction stall (low = done); iload output 32 instruction read data.
REQ-007 SHALL have ports dwait output 1 data stall (low = done); dload output 32 data read data.
REQ-008 SHALL have ports ramREN output 1; ramWEN output 1; ramaddr output 32; ramstore output 32; ramload input 32; ramrdy input 1 (access complete this cycle).
REQ-009 SHALL have port err  output 1  sticky RAM timeout flag.

Function
REQ-010 SHALL implement FSM states IDLE, DACC, IACC, DRSP, IRSP.
REQ-011 IDLE: if dREN|dWEN -> DACC, else if iREN -> IACC, else stay; data strictly outranks instruction.
REQ-012 On leaving IDLE SHALL latch op (write if dWEN, even with dREN also high), address and store data; requester changes after that cycle are ignored until the next IDLE.
REQ-013 DACC/IACC: SHALL drive ramaddr/ramstore from latched values, ramREN=1 for reads, ramWEN=1 for writes, never both.
REQ-014 DACC/IACC with ramrdy=1: SHALL capture ramload (reads only) into dload/iload register and go to DRSP/IRSP; ram strobes low in the response state.
REQ-015 DRSP: dwait=0 for exactly one cycle, dload holds captured value; IRSP likewise for iwait/iload; next state IDLE.
REQ-016 iwait and dwait SHALL be 1 in all other states.
REQ-017 Minimum latency: request sampled in IDLE at cycle N, RAM driven N+1, ramrdy at N+1 gives wait low at N+2.
REQ-018 dload/iload SHALL hold their last captured value until the next capture of the same port; writes do not alter dload.
REQ-019 Request withdrawn mid-access: the RAM access SHALL complete and the response pulse SHALL still occur.
REQ-020 ramrdy outside DACC/IACC SHALL be ignored.

Reset
REQ-021 nRST=0 at a rising edge SHALL force state IDLE, iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, err=0, watchdog count 0.
REQ-022 Reset mid-access SHALL abandon the access with no response pulse; ram strobes low the cycle after the reset edge.

Configuration
REQ-023 Macro MEMCTL_WATCHDOG_EN defined: counter clears on entering DACC/IACC, increments each access cycle without ramrdy; when count equals TIMEOUT-1 without ramrdy, SHALL abort to DRSP/IRSP, return 32'hBAD1BAD1 as read data (reads), and set err (cleared only by reset).
REQ-024 Macro MEMCTL_WATCHDOG_EN undefined: SHALL wait indefinitely for ramrdy; err tied 0; no counter logic.

Verification
REQ-025 Reset, then iREN=1 iaddr=0x40, ramrdy high whenever strobed, ramload=0x8C220004 -> iwait low at cycle 2 after request, iload=0x8C220004, ramaddr=0x40.
REQ-026 iREN=1 and dREN=1 same cycle, daddr=0x100 -> data served first (ramaddr=0x100, dwait pulse), then instruction access, iwait pulse 2 cycles later.
REQ-027 dREN=1, dWEN=1, daddr=0x200, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dload unchanged.
REQ-028 ramrdy delayed 5 cycles -> dwait stays 1 for 5 access cycles, pulses low exactly once, one cycle.
REQ-029 MEMCTL_WATCHDOG_EN, TIMEOUT=8, ramrdy never asserted on a read -> dwait low after 8 access cycles, dload=0xBAD1BAD1, err=1 and stays 1 until nRST.
REQ-030 nRST=0 during DACC -> no dwait pulse, all outputs at reset values next cycle.
